// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the write-back port arbiter: select encodings,
// FSM states and register-file widths.
package wb_port_arbiter_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] WB_MEM  = 2'b00;
  localparam logic [1:0] WB_ALU  = 2'b01;
  localparam logic [1:0] WB_PC   = 2'b10;
  localparam logic [1:0] WB_ZERO = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_FORCE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/wb_late_fifo.sv
// Circular buffer for late results. Each entry carries a valid bit that a
// matching pipeline write can clear; cleared entries still occupy a slot
// until popped.
module wb_late_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         push_kill,
  input  logic [REG_W-1:0]             push_rd,
  input  logic [DATA_W-1:0]            push_data,
  input  logic                         pop,
  input  logic                         inval,
  input  logic [REG_W-1:0]             inval_rd,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         head_ok,
  output logic [REG_W-1:0]             head_rd,
  output logic [DATA_W-1:0]            head_data
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [REG_W-1:0]  rd_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  ok_q;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  assign head_ok   = ok_q[rd_ptr];
  assign head_rd   = rd_q[rd_ptr];
  assign head_data = data_q[rd_ptr];

  // Pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Per-entry valid bits: rd-match invalidation, then the incoming entry
  // (which is killed when it matches the same-cycle pipeline write).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ok_q <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (inval && rd_q[i] == inval_rd) ok_q[i] <= 1'b0;
      end
      if (push) ok_q[wr_ptr] <= !push_kill;
    end
  end

  // Entry payload storage.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[wr_ptr]   <= push_rd;
      data_q[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the pipeline WB
// stage and buffered long-latency results, forcing a drain when a buffered
// result has waited too long.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned AGE_LIMIT  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_valid,
  input  logic              pipe_we,
  input  logic [REG_W-1:0]  pipe_rd,
  input  logic [1:0]        pipe_wb_sel,
  input  logic [DATA_W-1:0] pipe_mem,
  input  logic [DATA_W-1:0] pipe_alu,
  input  logic [DATA_W-1:0] pipe_next_pc,
  input  logic              late_valid,
  input  logic [REG_W-1:0]  late_rd,
  input  logic [DATA_W-1:0] late_data,
  output logic              late_ready,
  output logic              stall_pipe,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_rd,
  output logic [DATA_W-1:0] rf_wdata
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned AW = $clog2(AGE_LIMIT + 1);

  arb_state_t        state;
  logic [AW-1:0]     age;
  logic [AW-1:0]     age_inc;
  logic [CW-1:0]     count;
  logic [CW-1:0]     cnt_next;
  logic              active;
  logic              pop;
  logic              valid_pop;
  logic              push;
  logic              push_kill;
  logic              head_ok;
  logic [REG_W-1:0]  head_rd;
  logic [DATA_W-1:0] head_data;
  logic [DATA_W-1:0] pipe_data;

  assign stall_pipe = (state == ST_FORCE);
  assign active     = pipe_valid && pipe_we && (pipe_rd != '0) && !stall_pipe;
  // A dead head never needs the port, so it drains even under pipe writes.
  assign pop        = (count != '0) && (!active || !head_ok);
  assign valid_pop  = pop && head_ok;
  assign late_ready = (count < CW'(FIFO_DEPTH)) || pop;
  assign push       = late_valid && late_ready && (late_rd != '0);
  assign push_kill  = active && (late_rd == pipe_rd);
  assign age_inc    = (age == AW'(AGE_LIMIT)) ? age : age + 1'b1;

  // Write-back source select and next occupancy.
  always_comb begin
    unique case (pipe_wb_sel)
      WB_MEM:  pipe_data = pipe_mem;
      WB_ALU:  pipe_data = pipe_alu;
      WB_PC:   pipe_data = pipe_next_pc;
      default: pipe_data = '0;
    endcase
    cnt_next = count;
    if (push && !pop)      cnt_next = count + 1'b1;
    else if (pop && !push) cnt_next = count - 1'b1;
  end

  wb_late_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_kill (push_kill),
    .push_rd   (late_rd),
    .push_data (late_data),
    .pop       (pop),
    .inval     (active),
    .inval_rd  (pipe_rd),
    .count     (count),
    .head_ok   (head_ok),
    .head_rd   (head_rd),
    .head_data (head_data)
  );

  // Buffer-age FSM: IDLE when empty, PEND while waiting, FORCE for one drain cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      age   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          age <= '0;
          if (cnt_next != '0) state <= ST_PEND;
        end
        ST_PEND: begin
          if (cnt_next == '0) begin
            state <= ST_IDLE;
            age   <= '0;
          end else if (valid_pop) begin
            age <= '0;
          end else begin
            age <= age_inc;
            if (age_inc == AW'(AGE_LIMIT)) state <= ST_FORCE;
          end
        end
        ST_FORCE: begin
          if (cnt_next == '0) begin
            state <= ST_IDLE;
            age   <= '0;
          end else begin
            state <= ST_PEND;
            if (valid_pop) age <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          age   <= '0;
        end
      endcase
    end
  end

  // Registered register-file write port; rd/wdata hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
    end else if (active) begin
      rf_we    <= 1'b1;
      rf_rd    <= pipe_rd;
      rf_wdata <= pipe_data;
    end else if (valid_pop) begin
      rf_we    <= 1'b1;
      rf_rd    <= head_rd;
      rf_wdata <= head_data;
    end else begin
      rf_we    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized bench for wb_port_arbiter with a queue-based reference model.
module tb_wb_port_arbiter;

  localparam int unsigned FD = 2;
  localparam int unsigned AL = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pipe_valid = 1'b0;
  logic        pipe_we = 1'b0;
  logic [4:0]  pipe_rd = '0;
  logic [1:0]  pipe_wb_sel = '0;
  logic [31:0] pipe_mem = '0;
  logic [31:0] pipe_alu = '0;
  logic [31:0] pipe_next_pc = '0;
  logic        late_valid = 1'b0;
  logic [4:0]  late_rd = '0;
  logic [31:0] late_data = '0;
  logic        late_ready;
  logic        stall_pipe;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;

  int total = 0;
  int bad = 0;

  // Reference model state
  logic [4:0]  q_rd[$];
  logic [31:0] q_dat[$];
  bit          q_ok[$];
  bit          m_force = 0;
  int          m_age = 0;
  logic        m_we = 0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_wd = '0;

  always #5 clk = ~clk;

  wb_port_arbiter #(
    .FIFO_DEPTH (FD),
    .AGE_LIMIT  (AL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pipe_valid   (pipe_valid),
    .pipe_we      (pipe_we),
    .pipe_rd      (pipe_rd),
    .pipe_wb_sel  (pipe_wb_sel),
    .pipe_mem     (pipe_mem),
    .pipe_alu     (pipe_alu),
    .pipe_next_pc (pipe_next_pc),
    .late_valid   (late_valid),
    .late_rd      (late_rd),
    .late_data    (late_data),
    .late_ready   (late_ready),
    .stall_pipe   (stall_pipe),
    .rf_we        (rf_we),
    .rf_rd        (rf_rd),
    .rf_wdata     (rf_wdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q_rd.delete();
    q_dat.delete();
    q_ok.delete();
    m_force = 0;
    m_age   = 0;
    m_we    = 0;
    m_rd    = '0;
    m_wd    = '0;
  endtask

  // One cycle: check registered outputs, drive inputs, check late_ready, advance model.
  task automatic step(input logic pv, input logic pwe, input logic [4:0] prd,
                      input logic [1:0] psel, input logic [31:0] pm,
                      input logic [31:0] pa, input logic [31:0] pp,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    bit act, pop, rdy, vpop, was_force, busy;
    int sz;
    logic [31:0] sval;
    @(negedge clk);
    check_eq("rf_we", {31'd0, rf_we}, {31'd0, m_we});
    check_eq("rf_rd", {27'd0, rf_rd}, {27'd0, m_rd});
    check_eq("rf_wdata", rf_wdata, m_wd);
    check_eq("stall_pipe", {31'd0, stall_pipe}, {31'd0, m_force});
    pipe_valid = pv; pipe_we = pwe; pipe_rd = prd; pipe_wb_sel = psel;
    pipe_mem = pm; pipe_alu = pa; pipe_next_pc = pp;
    late_valid = lv; late_rd = lrd; late_data = ld;
    #1;
    case (psel)
      2'b00: sval = pm;
      2'b01: sval = pa;
      2'b10: sval = pp;
      default: sval = 32'd0;
    endcase
    sz   = q_rd.size();
    act  = pv && pwe && (prd != 0) && !m_force;
    pop  = (sz != 0) && (!act || !q_ok[0]);
    rdy  = (sz < FD) || pop;
    vpop = pop && q_ok[0];
    check_eq("late_ready", {31'd0, late_ready}, {31'd0, rdy});
    if (act) begin
      m_we = 1; m_rd = prd; m_wd = sval;
    end else if (vpop) begin
      m_we = 1; m_rd = q_rd[0]; m_wd = q_dat[0];
    end else begin
      m_we = 0;
    end
    if (pop) begin
      void'(q_rd.pop_front());
      void'(q_dat.pop_front());
      void'(q_ok.pop_front());
    end
    if (act) foreach (q_rd[i]) if (q_rd[i] == prd) q_ok[i] = 0;
    if (lv && rdy && lrd != 0) begin
      q_rd.push_back(lrd);
      q_dat.push_back(ld);
      q_ok.push_back(!(act && lrd == prd));
    end
    busy      = (sz != 0);
    was_force = m_force;
    m_force   = 0;
    if (q_rd.size() == 0) m_age = 0;
    else if (was_force) begin
      if (vpop) m_age = 0;
    end else if (busy) begin
      if (vpop) m_age = 0;
      else begin
        if (m_age < AL) m_age++;
        if (m_age == AL) m_force = 1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    pipe_valid = 0; pipe_we = 0; late_valid = 0;
    #1;
    check_eq("rst_rf_we", {31'd0, rf_we}, 32'd0);
    check_eq("rst_rf_rd", {27'd0, rf_rd}, 32'd0);
    check_eq("rst_rf_wdata", rf_wdata, 32'd0);
    check_eq("rst_stall", {31'd0, stall_pipe}, 32'd0);
    check_eq("rst_late_ready", {31'd0, late_ready}, 32'd1);
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int pbias, lbias;
    do_reset();

    // Pipe ALU write to x5
    step(1, 1, 5, 2'b01, 32'h0, 32'h1234, 32'h0, 0, 0, 0);
    idle(2);

    // Late result to x7 with idle pipe
    step(0, 0, 0, 0, 0, 0, 0, 1, 7, 32'hAA);
    idle(3);

    // Busy pipe, two late pushes, third offer refused, then forced drain
    step(1, 1, 1, 2'b01, 0, 32'h11, 0, 1, 10, 32'hA0);
    step(1, 1, 2, 2'b01, 0, 32'h22, 0, 1, 11, 32'hB0);
    step(1, 1, 3, 2'b01, 0, 32'h33, 0, 1, 12, 32'hC0);
    for (int k = 0; k < 12; k++) step(1, 1, 5'(k + 1), 2'b00, 32'(k), 0, 0, 0, 0, 0);
    idle(3);

    // Buffered x9 overwritten by pipe write to x9
    step(1, 1, 3, 2'b01, 0, 32'h3, 0, 1, 9, 32'hDEAD);
    step(1, 1, 9, 2'b00, 32'h55, 0, 0, 0, 0, 0);
    idle(4);

    // Same-cycle push and pipe write to the same register
    step(1, 1, 4, 2'b10, 0, 0, 32'h400, 1, 4, 32'hBEEF);
    idle(3);

    // rd=0 on both sides
    step(1, 1, 0, 2'b10, 0, 0, 32'h1000, 1, 0, 32'h77);
    idle(2);

    // Reset with two buffered entries
    step(1, 1, 1, 2'b01, 0, 32'h1, 0, 1, 13, 32'h13);
    step(1, 1, 2, 2'b01, 0, 32'h2, 0, 1, 14, 32'h14);
    do_reset();
    idle(6);

    // Randomized phases with varying pipe/late pressure
    for (int ph = 0; ph < 16; ph++) begin
      pbias = $urandom_range(0, 10);
      lbias = $urandom_range(1, 10);
      for (int k = 0; k < 200; k++) begin
        step($urandom_range(0, 9) < pbias, $urandom_range(0, 7) != 0,
             5'($urandom_range(0, 7)), 2'($urandom), $urandom, $urandom, $urandom,
             $urandom_range(0, 9) < lbias, 5'($urandom_range(0, 7)), $urandom);
      end
      if (ph == 7) do_reset();
    end
    idle(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
